// File: rtl/simon_playback_sequencer.sv
// Simon light playback: fetches count patterns from memory and lights each for
// ON_TICKS cycles, followed by OFF_TICKS blank cycles, then pulses done.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read strobe for pattern[index]
// LOAD  | memory data valid, captured into leds on exit
// SHOW  | pattern lit for ON_TICKS cycles
// GAP   | leds blank for OFF_TICKS cycles, then next entry or DONE
// DONE  | one-cycle completion pulse
module simon_playback_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int PAT_W     = 4,
  parameter int ON_TICKS  = 8,
  parameter int OFF_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PAT_W-1:0]  mem_rdata,
  output logic [PAT_W-1:0]  leds,
  output logic              busy,
  output logic              done
);

  localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHOW,
    GAP,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   index;
  logic [ADDR_W-1:0]   cnt_q;
  logic [TICK_W-1:0]   tick;
  logic [ADDR_W:0]     index_plus;
  logic                more;
  logic                accept;
  logic                kill;

  // one extra bit so index+1 never wraps when count is all ones
  assign index_plus = {1'b0, index} + 1'b1;
  assign more       = index_plus < {1'b0, cnt_q};
  assign accept     = (state == IDLE) && start && !abort;
  assign kill       = (state != IDLE) && abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    mem_addr   = index;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = (count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        mem_rd_en  = 1'b1;
        state_next = LOAD;
      end
      LOAD: state_next = SHOW;
      SHOW: if (tick == ON_LAST) state_next = GAP;
      GAP:  if (tick == OFF_LAST) state_next = more ? FETCH : DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index <= '0;
      cnt_q <= '0;
      tick  <= '0;
      leds  <= '0;
    end else if (kill) begin
      index <= '0;
      tick  <= '0;
      leds  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt_q <= count;
            index <= '0;
            tick  <= '0;
            leds  <= '0;
          end
        end
        LOAD: begin
          leds <= mem_rdata;
          tick <= '0;
        end
        SHOW: begin
          if (tick == ON_LAST) begin
            tick <= '0;
            leds <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        GAP: begin
          if (tick == OFF_LAST) begin
            tick  <= '0;
            index <= index + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DONE: leds <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Directed bench for simon_playback_sequencer with default parameters and a
// one-cycle-latency pattern memory model.
module tb_simon_playback_sequencer;

  localparam int PER = 14;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] count;
  logic       mem_rd_en;
  logic [5:0] mem_addr;
  logic [3:0] mem_rdata;
  logic [3:0] leds;
  logic       busy;
  logic       done;

  logic [3:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  simon_playback_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .count     (count),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .leds      (leds),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] c);
    count = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // called one step after the accepting edge; checks every cycle through done
  task automatic play_check(input int n);
    int ent, p;
    logic [3:0] exp_leds;
    for (int k = 0; k < n * PER; k++) begin
      ent = k / PER;
      p   = k % PER;
      exp_leds = (p >= 2 && p < 10) ? mem[ent] : 4'd0;
      chk("rd_en", mem_rd_en, (p == 0) ? 1 : 0);
      chk("addr", mem_addr, ent);
      chk("leds", leds, exp_leds);
      chk("done_early", done, 0);
      chk("busy_play", busy, 1);
      step();
    end
    chk("done_pulse", done, 1);
    chk("done_rd_en", mem_rd_en, 0);
    chk("done_leds", leds, 0);
    step();
    chk("after_busy", busy, 0);
    chk("after_done", done, 0);
  endtask

  int fetches, dones, done_at;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'(i);
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b1000;
    rst = 1'b0; start = 1'b0; abort = 1'b0; count = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_leds", leds, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    #10 rst = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // three entries, done 42 cycles after accept
    do_start(6'd3);
    play_check(3);

    // zero count goes straight to DONE
    do_start(6'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    chk("z_rd_en", mem_rd_en, 0);
    chk("z_leds", leds, 0);
    step();
    chk("z_idle", busy, 0);
    chk("z_done2", done, 0);

    // abort during second SHOW
    do_start(6'd3);
    repeat (19) step();
    chk("ab_leds_show", leds, 4'b0010);
    abort = 1'b1;
    step();
    chk("ab_busy", busy, 0);
    chk("ab_leds", leds, 0);
    chk("ab_done", done, 0);
    chk("ab_addr", mem_addr, 0);
    abort = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      step();
    end
    chk("ab_no_done", dones, 0);
    do_start(6'd3);
    chk("ab_re_rd", mem_rd_en, 1);
    chk("ab_re_addr", mem_addr, 0);
    step();
    step();
    chk("ab_re_leds", leds, 4'b0001);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // restart and count change while busy are ignored
    do_start(6'd2);
    fetches = 0; dones = 0; done_at = -1;
    for (int k = 0; k < 60; k++) begin
      if (mem_rd_en) fetches++;
      if (done) begin
        dones++;
        done_at = k;
      end
      start = (k == 5);
      if (k == 5) count = 6'd5;
      step();
    end
    start = 1'b0;
    chk("ig_fetches", fetches, 2);
    chk("ig_dones", dones, 1);
    chk("ig_done_at", done_at, 28);

    // async reset mid-cycle in GAP
    do_start(6'd3);
    repeat (11) step();
    chk("rs_gap_leds", leds, 0);
    chk("rs_gap_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_leds", leds, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_rd_en", mem_rd_en, 0);
    chk("rs_done", done, 0);
    #3 rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (busy || done) dones++;
    end
    chk("rs_stay_idle", dones, 0);

    // start with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_rd_en", mem_rd_en, 0);
    step();
    chk("sa_busy2", busy, 0);

    // full-range count plays every entry without wrapping
    do_start(6'd63);
    play_check(63);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/simon_playback_sequencer.md
SIMON_PLAYBACK_SEQUENCER -- requirements
Module: simon_playback_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the pattern-memory address width and the count width.
REQ-002 Parameter PAT_W, default 4, SHALL set the pattern width, one bit per Simon light.
REQ-003 Parameter ON_TICKS, default 8, SHALL set the cycles each entry is lit (legal range >=1).
REQ-004 Parameter OFF_TICKS, default 4, SHALL set the blank cycles after each entry (legal range >=1).
REQ-005 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-006 rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-007 start  input  1  one-cycle request to begin playback.
REQ-008 abort  input  1  cancel playback in progress.
REQ-009 count  input  ADDR_W  number of stored entries to play, sampled at accepted start.
REQ-010 mem_rd_en  output  1  read strobe to pattern memory.
REQ-011 mem_addr  output  ADDR_W  read address (current index).
REQ-012 mem_rdata  input  PAT_W  memory read data, valid the cycle after mem_rd_en.
REQ-013 leds  output  PAT_W  registered light drive.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 States SHALL be IDLE, FETCH, LOAD, SHOW, GAP, DONE.
REQ-017 IDLE: start=1 and abort=0 SHALL latch count into cnt_q, clear index to 0, go FETCH; if count==0, go DONE instead.
REQ-018 start while busy SHALL be ignored; count changes after acceptance SHALL be ignored.
REQ-019 FETCH (1 cycle): mem_rd_en=1, mem_addr=index; next state LOAD.
REQ-020 LOAD (1 cycle): mem_rd_en=0; leds register SHALL capture mem_rdata on the exit edge; next state SHOW.
REQ-021 SHOW: leds hold the captured pattern for exactly ON_TICKS cycles via a tick counter cleared on entry; then GAP.
REQ-022 GAP: leds=0 for exactly OFF_TICKS cycles; on exit, index increments; if index+1 < cnt_q, go FETCH, else DONE.
REQ-023 DONE (1 cycle): done=1, leds=0; next state IDLE.
REQ-024 Per-entry period SHALL be 2+ON_TICKS+OFF_TICKS cycles; start accepted at edge E gives done high in the cycle beginning at E + count*(2+ON_TICKS+OFF_TICKS) cycles.
REQ-025 mem_addr SHALL equal index in all states; mem_rd_en SHALL be high only in FETCH.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with leds=0, index=0, and no done pulse; abort has priority over start and over every transition.
REQ-027 count = 2^ADDR_W-1 SHALL play all entries; index SHALL never wrap within a playback.
REQ-028 Tick counter width SHALL cover max(ON_TICKS, OFF_TICKS) without overflow.
REQ-029 done and mem_rd_en SHALL never be high in the same cycle.

Reset
REQ-030 rst=0 SHALL immediately force state=IDLE, index=0, cnt_q=0, tick=0, leds=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, regardless of clk.
REQ-031 Reset asserted mid-playback SHALL abandon playback with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-032 Defaults, count=3, memory {0:0001, 1:0010, 2:1000}, start pulse -> leds show 0001, 0010, 1000 for 8 cycles each with 4 zero cycles between; mem_addr 0,1,2; done exactly 42 cycles after start edge.
REQ-033 count=0, start -> DONE the next cycle, done pulse, mem_rd_en never high, leds stay 0.
REQ-034 count=3, abort asserted during second SHOW -> IDLE next edge, leds=0, busy=0, no done; a new start replays from index 0.
REQ-035 start re-pulsed and count changed to 5 during playback of count=2 -> ignored; exactly 2 entries played, done once.
REQ-036 rst driven to 0 between clock edges during GAP -> all outputs 0 immediately; after release, idle until start.
REQ-037 start and abort together in IDLE -> stays IDLE, busy=0.
